fetch_stage: RTL and testbench

- Instruction-fetch stage feeding the decode stage, where the register file and immediate sign-extension consume the 32-bit instruction word.
- Holds the PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO, drained by decode through a valid/ready handshake.
- Accepts taken-branch redirects, which flush all speculative fetch state.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Holds the fetch PC, issues one read per cycle to a
//   synchronous instruction memory (1-cycle read latency), and buffers each
//   returned word with its PC in a DEPTH-entry FIFO. Decode drains the FIFO
//   through a valid/ready handshake. A taken branch flushes the FIFO and drops
//   any in-flight response, then restarts fetch at the word-aligned target.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   imem_req       read strobe to instruction memory
//   imem_addr      read address (the fetch PC)
//   imem_rdata     instruction word, valid the cycle after a request
//   branch_taken   redirect strobe from execute
//   branch_target  redirect PC (low two bits ignored)
//   instr_d        head instruction to decode (0 when empty)
//   pc_d           PC of instr_d (0 when empty)
//   valid_d        head entry is valid
//   ready_d        decode accepts the head this cycle

module fetch_stage #(
   parameter int             N        = 64,
   parameter int             DEPTH    = 2,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset,
   output logic           imem_req,
   output logic [N-1:0]   imem_addr,
   input  logic [31:0]    imem_rdata,
   input  logic           branch_taken,
   input  logic [N-1:0]   branch_target,
   output logic [31:0]    instr_d,
   output logic [N-1:0]   pc_d,
   output logic           valid_d,
   input  logic           ready_d
);

   localparam int           PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int           CW      = PTR_W + 1;
   localparam logic [CW:0]  DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [N-1:0] PC_STEP = N'(4);

   logic [N-1:0]     fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic [N-1:0]     inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [31:0]      instr_mem_q [DEPTH];
   logic [N-1:0]     pc_mem_q    [DEPTH];

   logic             fifo_valid;
   logic             pop;
   logic             push;
   logic             issue;
   logic [CW:0]      occupancy;

   // The two low target bits are forced to zero and never read.
   logic             unused_tgt_bits;
   assign unused_tgt_bits = ^branch_target[1:0];

   assign fifo_valid = (count_q != '0);

   always_comb begin
      pop  = fifo_valid & ready_d & ~branch_taken;
      push = inflight_q & ~branch_taken;
      // Credit check: entries held plus the response still coming back, less
      // the one leaving this cycle, must leave room for one more request.
      occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue     = ~reset & ~branch_taken & (occupancy < DEPTH_W);
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (branch_taken) begin
         fetch_pc_d = {branch_target[N-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Entry storage needs no reset; the outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push & ~reset) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      end
   end

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;
   assign valid_d   = fifo_valid;
   assign instr_d   = fifo_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign pc_d      = fifo_valid ? pc_mem_q[rd_ptr_q]    : '0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam int N = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          imem_req;
   logic [N-1:0]  imem_addr;
   logic [31:0]   imem_rdata;
   logic          branch_taken;
   logic [N-1:0]  branch_target;
   logic [31:0]   instr_d;
   logic [N-1:0]  pc_d;
   logic          valid_d;
   logic          ready_d;

   int n_pass  = 0;
   int n_total = 0;
   bit inv_en  = 1'b0;

   fetch_stage #(.N(N), .DEPTH(2), .RESET_PC('0)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .valid_d       (valid_d),
      .ready_d       (ready_d)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: word = addr[31:0] ^ 32'hF800_0000.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= imem_addr[31:0] ^ 32'hF800_0000;
   end

   typedef struct {
      logic          rst;
      logic          rdy;
      logic          bt;
      logic [N-1:0]  tgt;
      logic          chk_all;
      logic          req;
      logic [N-1:0]  addr;
      logic          vld;
      logic [N-1:0]  pc;
      logic [31:0]   ins;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic rst, input logic rdy, input logic bt,
                               input logic [N-1:0] tgt, input logic chk_all,
                               input logic req, input logic [N-1:0] addr,
                               input logic vld, input logic [N-1:0] pc,
                               input logic [31:0] ins);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.bt = bt; v.tgt = tgt; v.chk_all = chk_all;
      v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.ins = ins;
      return v;
   endfunction

   // Inputs change 1 time unit after a rising edge; outputs sampled at the
   // falling edge, then the cycle is closed by the next rising edge.
   task automatic apply(input vec_t v, input string tag);
      reset         = v.rst;
      ready_d       = v.rdy;
      branch_taken  = v.bt;
      branch_target = v.tgt;
      @(negedge clk);
      chk({tag, ".imem_req"}, 64'(imem_req), 64'(v.req));
      if (v.chk_all) begin
         chk({tag, ".imem_addr"}, imem_addr, v.addr);
         chk({tag, ".valid_d"},   64'(valid_d), 64'(v.vld));
         chk({tag, ".pc_d"},      pc_d, v.pc);
         chk({tag, ".instr_d"},   64'(instr_d), 64'(v.ins));
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (inv_en)
         chk("count_plus_inflight_le_depth",
             64'(int'(dut.count_q) + int'(dut.inflight_q) <= 2), 64'd1);
   end

   initial begin
      logic [N-1:0] exp_pc;
      logic         after_bt;
      int           pops;

      // Streaming from reset, decode always ready.
      tbl[0]  = mk(1, 1, 0, 0, 1, 0, 64'h0,  0, 64'h0,  32'h0);
      tbl[1]  = mk(0, 1, 0, 0, 1, 1, 64'h0,  0, 64'h0,  32'h0);
      tbl[2]  = mk(0, 1, 0, 0, 1, 1, 64'h4,  0, 64'h0,  32'h0);
      tbl[3]  = mk(0, 1, 0, 0, 1, 1, 64'h8,  1, 64'h0,  32'hF800_0000);
      tbl[4]  = mk(0, 1, 0, 0, 1, 1, 64'hC,  1, 64'h4,  32'hF800_0004);
      tbl[5]  = mk(0, 1, 0, 0, 1, 1, 64'h10, 1, 64'h8,  32'hF800_0008);
      tbl[6]  = mk(0, 1, 0, 0, 1, 1, 64'h14, 1, 64'hC,  32'hF800_000C);
      // Reset again, then stall decode until the FIFO fills.
      tbl[7]  = mk(1, 0, 0, 0, 0, 0, 64'h0,  0, 64'h0,  32'h0);
      tbl[8]  = mk(1, 0, 0, 0, 1, 0, 64'h0,  0, 64'h0,  32'h0);
      tbl[9]  = mk(0, 0, 0, 0, 1, 1, 64'h0,  0, 64'h0,  32'h0);
      tbl[10] = mk(0, 0, 0, 0, 1, 1, 64'h4,  0, 64'h0,  32'h0);
      tbl[11] = mk(0, 0, 0, 0, 1, 0, 64'h8,  1, 64'h0,  32'hF800_0000);
      tbl[12] = mk(0, 0, 0, 0, 1, 0, 64'h8,  1, 64'h0,  32'hF800_0000);
      tbl[13] = mk(0, 0, 0, 0, 1, 0, 64'h8,  1, 64'h0,  32'hF800_0000);
      tbl[14] = mk(0, 1, 0, 0, 1, 1, 64'h8,  1, 64'h0,  32'hF800_0000);
      tbl[15] = mk(0, 1, 0, 0, 1, 1, 64'hC,  1, 64'h4,  32'hF800_0004);
      tbl[16] = mk(0, 1, 0, 0, 1, 1, 64'h10, 1, 64'h8,  32'hF800_0008);

      reset = 1'b1; ready_d = 1'b0; branch_taken = 1'b0; branch_target = '0;
      @(posedge clk);
      #1;
      inv_en = 1'b1;

      for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("row%0d", i));

      // Redirect with one entry buffered and one in flight.
      apply(mk(0, 1, 1, 64'h100, 1, 0, 64'h14,  1, 64'hC,   32'hF800_000C), "br100_a");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h100, 0, 64'h0,   32'h0),         "br100_b");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h104, 0, 64'h0,   32'h0),         "br100_c");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h108, 1, 64'h100, 32'hF800_0100), "br100_d");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h10C, 1, 64'h104, 32'hF800_0104), "br100_e");

      // Redirect coinciding with a handshake; target low bits are dropped.
      apply(mk(0, 1, 1, 64'h203, 1, 0, 64'h110, 1, 64'h108, 32'hF800_0108), "br203_a");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h200, 0, 64'h0,   32'h0),         "br203_b");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h204, 0, 64'h0,   32'h0),         "br203_c");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h208, 1, 64'h200, 32'hF800_0200), "br203_d");
      apply(mk(0, 1, 0, 64'h0,   1, 1, 64'h20C, 1, 64'h204, 32'hF800_0204), "br203_e");

      // PC wraps past the top of the address space.
      apply(mk(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 64'h210, 1, 64'h208, 32'hF800_0208), "wrap_a");
      apply(mk(0, 1, 0, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0),            "wrap_b");
      apply(mk(0, 1, 0, 64'h0, 1, 1, 64'h0, 0, 64'h0, 32'h0),                              "wrap_c");
      apply(mk(0, 1, 0, 64'h0, 1, 1, 64'h4, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h07FF_FFFC),    "wrap_d");
      apply(mk(0, 1, 0, 64'h0, 1, 1, 64'h8, 1, 64'h0, 32'hF800_0000),                      "wrap_e");

      // One-cycle reset mid-stream with a response in flight; the restart
      // must replay the opening sequence exactly.
      apply(mk(1, 1, 0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 32'h0), "midrst");
      for (int i = 1; i < 7; i++) apply(tbl[i], $sformatf("postrst%0d", i));

      // Random decode back-pressure and redirects against a program-order model.
      apply(mk(1, 0, 0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 32'h0), "rand_rst");
      exp_pc   = '0;
      after_bt = 1'b0;
      pops     = 0;
      for (int c = 0; c < 10000; c++) begin
         reset         = 1'b0;
         ready_d       = 1'($urandom_range(0, 1));
         branch_taken  = ($urandom_range(0, 15) == 0);
         branch_target = {$urandom, $urandom};
         @(negedge clk);
         if (after_bt) chk("rand_empty_after_redirect", 64'(valid_d), 64'd0);
         if (valid_d && ready_d && !branch_taken) begin
            chk("rand_pc_d", pc_d, exp_pc);
            chk("rand_instr_d", 64'(instr_d), 64'(exp_pc[31:0] ^ 32'hF800_0000));
            exp_pc = exp_pc + 64'd4;
            pops++;
         end
         if (branch_taken) exp_pc = {branch_target[N-1:2], 2'b00};
         after_bt = branch_taken;
         @(posedge clk);
         #1;
      end
      chk("rand_enough_pops", 64'(pops > 1000), 64'd1);

      inv_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
